run_length_serializer: RTL and testbench

// Transmit-side counterpart of the serial run detector. Accepts (bit, length)
// run commands over a valid/ready handshake and serializes each one as
// `length` consecutive copies of `bit`, one per clock, onto a single-bit stream.

---
 rtl/run_length_serializer_if.sv | 12 +
 rtl/run_length_serializer.sv | 99 +++++++++
 tb/tb_run_length_serializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/run_length_serializer_if.sv
// Run-command handshake between a command source and run_length_serializer.
interface run_length_serializer_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_bit;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_bit, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_bit, cmd_len, output cmd_ready);
endinterface

// File: rtl/run_length_serializer.sv
// Serializes (bit, length) run commands onto a single-bit stream and flags
// every bit that is the 3rd or later consecutive equal emitted bit.
module run_length_serializer #(
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  run_length_serializer_if.slave  cmd,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    run3,
  output logic                    busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining, remaining_nx;
  logic             last_bit;
  logic [1:0]       run_cnt, run_cnt_nx;
  logic             accept, emit, emit_bit;

  // remaining counts the bits of the run not yet retired, including the one
  // currently on bit_out, so remaining==1 marks the last bit of the run.
  assign cmd.cmd_ready = (state == IDLE) || (remaining == LEN_W'(1));
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign bit_valid     = (state == SEND);
  assign busy          = (state == SEND);

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    emit         = 1'b0;
    emit_bit     = bit_out;
    case (state)
      IDLE: begin
        if (accept && (cmd.cmd_len != '0)) begin
          state_nx     = SEND;
          remaining_nx = cmd.cmd_len;
          emit         = 1'b1;
          emit_bit     = cmd.cmd_bit;
        end
      end
      SEND: begin
        if (remaining != LEN_W'(1)) begin
          remaining_nx = remaining - LEN_W'(1);
          emit         = 1'b1;
        end else if (accept && (cmd.cmd_len != '0)) begin
          remaining_nx = cmd.cmd_len;
          emit         = 1'b1;
          emit_bit     = cmd.cmd_bit;
        end else begin
          state_nx     = IDLE;
          remaining_nx = '0;
        end
      end
      default: begin
        state_nx     = IDLE;
        remaining_nx = '0;
      end
    endcase
  end

  always_comb begin
    run_cnt_nx = run_cnt;
    if (emit) begin
      if (emit_bit != last_bit)
        run_cnt_nx = 2'd1;
      else if (run_cnt != 2'd3)
        run_cnt_nx = run_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      bit_out   <= 1'b0;
      run3      <= 1'b0;
      last_bit  <= 1'b0;
      run_cnt   <= '0;
    end else begin
      remaining <= remaining_nx;
      if (emit) begin
        bit_out  <= emit_bit;
        last_bit <= emit_bit;
        run_cnt  <= run_cnt_nx;
        run3     <= (run_cnt_nx == 2'd3);
      end
    end
  end

endmodule

// File: tb/tb_run_length_serializer.sv
// Scoreboard bench: a stream-level model schedules each expected bit by cycle;
// a monitor compares the DUT stream, run3, busy and cmd_ready against it.
module tb_run_length_serializer;
  localparam int LEN_W = 4;

  logic clk, rst_n;
  logic bit_out, bit_valid, run3, busy;

  run_length_serializer_if #(.LEN_W(LEN_W)) ifc ();

  run_length_serializer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (ifc.slave),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .run3      (run3),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic b;
    logic r3;
  } item_t;

  item_t q[$];
  int    cyc        = 0;
  int    last_sched = 0;
  int    acc_cyc    = -1;
  int    post_rst   = -1;
  bit    armed      = 1'b0;
  logic  m_last     = 1'b0;
  int    m_cnt      = 0;
  int    n_cmp      = 0;
  int    n_bad      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each accepted run is expanded into per-cycle bits.
  initial forever begin
    int t;
    @(posedge clk);
    t = cyc;
    if (!rst_n) begin
      q.delete();
      m_last     = 1'b0;
      m_cnt      = 0;
      last_sched = 0;
      post_rst   = t + 1;
      armed      = 1'b1;
    end else if (ifc.cmd_valid && (last_sched <= t)) begin
      acc_cyc = t + 1;
      for (int i = 0; i < int'(ifc.cmd_len); i++) begin
        item_t it;
        if (ifc.cmd_bit == m_last) m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
        else m_cnt = 1;
        m_last = ifc.cmd_bit;
        it.cyc = t + 1 + i;
        it.b   = ifc.cmd_bit;
        it.r3  = (m_cnt == 3);
        q.push_back(it);
      end
      if (ifc.cmd_len != '0) last_sched = t + int'(ifc.cmd_len);
    end
    cyc = t + 1;
  end

  // Monitor: compares whatever the DUT presents against the scheduled stream.
  initial forever begin
    logic exp_v;
    @(negedge clk);
    if (armed) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_bit", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      chk("bit_valid", 32'(bit_valid), 32'(exp_v));
      chk("busy", 32'(busy), 32'(exp_v));
      chk("cmd_ready", 32'(ifc.cmd_ready), 32'(last_sched <= cyc));
      if (exp_v) begin
        if (bit_valid) begin
          chk("bit_out", 32'(bit_out), 32'(q[0].b));
          chk("run3", 32'(run3), 32'(q[0].r3));
        end
        void'(q.pop_front());
      end
      if (cyc == post_rst) begin
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_run3", 32'(run3), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic b, input int unsigned len);
    int n;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_bit   = b;
    ifc.cmd_len   = LEN_W'(len);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (acc_cyc != cyc && n < 100);
    if (acc_cyc != cyc) chk("accept_timeout", 32'd0, 32'd1);
    ifc.cmd_valid = 1'b0;
    ifc.cmd_bit   = $urandom_range(0, 1);
    ifc.cmd_len   = LEN_W'($urandom_range(0, 15));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_bit   = 1'b1;
    ifc.cmd_len   = LEN_W'(5);
    idle(3);
    rst_n         = 1'b1;
    ifc.cmd_valid = 1'b0;
    idle(2);

    send(1'b1, 5);
    idle(7);

    send(1'b0, 2);
    send(1'b0, 2);
    idle(5);

    send(1'b1, 2);
    idle(3);
    send(1'b1, 1);
    send(1'b0, 3);
    idle(6);

    send(1'b1, 0);
    idle(2);
    send(1'b0, 3);
    send(1'b1, 0);
    idle(5);

    send(1'b1, 10);
    idle(3);
    pulse_reset();
    idle(2);
    send(1'b1, 2);
    idle(5);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      send(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(25);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
